rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters, e.g. the 8-input selector or one counter instance.
- Issues a one-hot grant and a 3-bit index; grant_idx drives the resource's select input directly.
- Each grant is held until the owner signals done, then rotates priority.
- Sits between the requester blocks and the shared datapath.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter_8.sv | 88 ++++++++
 tb/tb_rr_arbiter_8.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// The hold-timeout constants apply only when RR_ARB_TIMEOUT_EN is defined.
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 4;

    // Longest a single grant may be held before a forced release (1..15).
    localparam logic [HOLD_W-1:0] MAX_HOLD = 4'd15;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: returns the first asserted request found when
// searching from ptr upward, wrapping from 7 back to 0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// Define RR_ARB_TIMEOUT_EN to add the hold-limit forced release and timeout pulse.
module rr_arbiter_8
    import arb_pkg::*;
(
    input  logic       CP,
    input  logic       CR,
    input  logic       n_EN,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_vld,
    output logic       timeout
);

    // Handshake: grant/grant_vld is the valid side; the owner keeps req high
    // while it uses the resource and pulses done (or drops req) to hand it back.
    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             found;
    logic             owner_rel;
    logic             force_rel;
    logic             release_now;
    logic             take_grant;

    assign owner_rel   = done || !req[grant_idx];
    assign release_now = (state == S_GRANT) && (owner_rel || force_rel);
    // While granted, the search for the next owner starts just past the current one.
    assign pick_ptr    = (state == S_GRANT) ? grant_idx + 3'd1 : ptr;
    assign take_grant  = !n_EN && found && ((state == S_IDLE) || release_now);

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (found)
    );

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
        end else begin
            if (release_now)
                ptr <= grant_idx + 3'd1;
            if (take_grant) begin
                state     <= S_GRANT;
                grant_idx <= pick_idx;
                grant     <= 8'(1) << pick_idx;
                grant_vld <= 1'b1;
            end else if (release_now) begin
                state     <= S_IDLE;
                grant     <= '0;
                grant_vld <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    assign force_rel = (state == S_GRANT) && (hold_cnt + HOLD_W'(1) == MAX_HOLD);

    // A release by the owner on the limit cycle is a normal release, not a timeout.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel && !owner_rel;
            if (take_grant)
                hold_cnt <= '0;
            else if (state == S_GRANT)
                hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed vector table, corner-case sequences and
// randomized traffic checked against a rule-level reference model.
module tb_rr_arbiter_8;

  logic       CP;
  logic       CR;
  logic       n_EN;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  rr_arbiter_8 dut (
    .CP        (CP),
    .CR        (CR),
    .n_EN      (n_EN),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_owner;   // -1 when nobody holds the resource
  int   m_idx;     // last granted index
  int   m_ptr;
  int   m_hold;
  logic m_to;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    int  p;
    bit  rel;
    bit  forced;
    if (m_owner < 0) begin
      m_to = 1'b0;
      p = n_EN ? -1 : pick(req, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_idx   = p;
        m_hold  = 0;
      end
    end else begin
      rel    = done || !req[m_owner];
      forced = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      if (!rel && (m_hold + 1 == 15)) forced = 1'b1;
`endif
      if (rel || forced) begin
        m_ptr = (m_owner + 1) % 8;
        m_to  = forced;
        p = n_EN ? -1 : pick(req, m_ptr);
        if (p >= 0) begin
          m_owner = p;
          m_idx   = p;
          m_hold  = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    model_edge();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset(input string tag);
    CR = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_grant"}, grant, 8'h00);
    chk({tag, "_rst_vld"}, grant_vld, 1'b0);
    chk({tag, "_rst_idx"}, grant_idx, 3'd0);
    chk({tag, "_rst_timeout"}, timeout, 1'b0);
    #1;
    CR = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] exp_g;
    exp_g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, "_grant"}, grant, exp_g);
    chk({tag, "_idx"}, grant_idx, m_idx[2:0]);
    chk({tag, "_vld"}, grant_vld, m_owner >= 0);
    chk({tag, "_timeout"}, timeout, m_to);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       n_en;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Rotation with all requesting, then abandon, sparse wrap, enable gating.
    tbl[0]  = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'hFF, 1'b1, 8'h02, 3'd1, 1'b1};
    tbl[2]  = '{1'b0, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[3]  = '{1'b0, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1};
    tbl[4]  = '{1'b0, 8'hFF, 1'b1, 8'h10, 3'd4, 1'b1};
    tbl[5]  = '{1'b0, 8'hFF, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[6]  = '{1'b0, 8'hFF, 1'b1, 8'h40, 3'd6, 1'b1};
    tbl[7]  = '{1'b0, 8'hFF, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[8]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[11] = '{1'b0, 8'h21, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[13] = '{1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[14] = '{1'b1, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[15] = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd5, 1'b0};
    tbl[16] = '{1'b0, 8'hFF, 1'b1, 8'h40, 3'd6, 1'b1};
    tbl[17] = '{1'b0, 8'hFF, 1'b0, 8'h40, 3'd6, 1'b1};
  end

  // ---------------- test sequence ----------------
  initial begin
    CR   = 1'b0;
    n_EN = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    model_reset();
    #12;
    chk("init_grant", grant, 8'h00);
    chk("init_vld", grant_vld, 1'b0);
    chk("init_idx", grant_idx, 3'd0);
    chk("init_timeout", timeout, 1'b0);
    CR = 1'b1;

    for (int i = 0; i < 18; i++) begin
      n_EN = tbl[i].n_en;
      req  = tbl[i].req;
      done = tbl[i].done;
      cyc();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_idx", i), grant_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_vld", i), grant_vld, tbl[i].vld);
    end
    done = 1'b0;

    // Reset while requester 6 owns the grant with everyone requesting.
    do_reset("midgrant");
    req = 8'h01;
    cyc();
    chk("post_rst_grant", grant, 8'h01);
    chk("post_rst_vld", grant_vld, 1'b1);

    // Owner 2 holds without done; requester 3 must not preempt.
    do_reset("hold");
    req = 8'h04;
    cyc();
    chk("hold_first", grant, 8'h04);
    req = 8'h0C;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("hold_c%0d", i), grant, 8'h04);
    end
    done = 1'b1;
    cyc();
    chk("hold_next_grant", grant, 8'h08);
    chk("hold_next_idx", grant_idx, 3'd3);
    done = 1'b0;

    // Disable during a grant to 4: grant finishes, then stays idle.
    do_reset("enable");
    req = 8'h10;
    cyc();
    chk("en_grant", grant, 8'h10);
    n_EN = 1'b1;
    req  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("en_held%0d", i), grant, 8'h10);
    end
    done = 1'b1;
    cyc();
    chk("en_rel_grant", grant, 8'h00);
    chk("en_rel_vld", grant_vld, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("en_idle%0d_grant", i), grant, 8'h00);
      chk($sformatf("en_idle%0d_vld", i), grant_vld, 1'b0);
      chk($sformatf("en_idle%0d_idx", i), grant_idx, 3'd4);
    end
    n_EN = 1'b0;

    // Requester 4 abandons its grant.
    do_reset("abandon");
    req = 8'h10;
    cyc();
    chk("ab_grant", grant, 8'h10);
    req = 8'h00;
    cyc();
    chk("ab_rel_grant", grant, 8'h00);
    chk("ab_rel_vld", grant_vld, 1'b0);
    chk("ab_rel_idx", grant_idx, 3'd4);

    // Owner 0 never signals done.
    do_reset("hog");
    req = 8'h03;
    cyc();
    chk("hog_grant", grant, 8'h01);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk($sformatf("hog_hold%0d_grant", i), grant, 8'h01);
      chk($sformatf("hog_hold%0d_to", i), timeout, 1'b0);
    end
    cyc();
    chk("hog_forced_grant", grant, 8'h02);
    chk("hog_forced_to", timeout, 1'b1);
    cyc();
    chk("hog_after_grant", grant, 8'h02);
    chk("hog_after_to", timeout, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("hog_hold%0d_grant", i), grant, 8'h01);
      chk($sformatf("hog_hold%0d_to", i), timeout, 1'b0);
    end
`endif

    // Randomized traffic against the reference model.
    do_reset("rand");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rand_mid");
      n_EN = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0)
        req = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 19) == 0);
      cyc();
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
